seq_generator: RTL and testbench

SEQ_GENERATOR -- requirements
Module: seq_generator

---
 rtl/seq_generator_if.sv | 32 +++
 rtl/seq_generator.sv | 157 +++++++++++++++
 tb/tb_seq_generator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_generator_if.sv
// Launch/serial-output bundle between a frame source (master) and seq_generator (slave).
interface seq_generator_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] pattern;
    logic              dout;
    logic              dout_vld;
    logic              busy;
    logic              done;
    logic [7:0]        seg;

    modport master (
        output start,
        output pattern,
        input  dout,
        input  dout_vld,
        input  busy,
        input  done,
        input  seg
    );

    modport slave (
        input  start,
        input  pattern,
        output dout,
        output dout_vld,
        output busy,
        output done,
        output seg
    );
endinterface

// File: rtl/seq_generator.sv
// Serialises a DATA_W-bit pattern MSB first, idles GAP cycles, and shows a 3-bit frame count on a 7-seg code.
// Macro SEQ_GEN_REPEAT_EN: level-sensitive start with back-to-back relaunch; undefined = single-shot on start rising edge.
module seq_generator #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_generator_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
    localparam logic [3:0]       LAST_GAP = 4'(GAP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        frame_cnt_q, frame_cnt_d;
    logic              launch_req;
    logic              load;

`ifdef SEQ_GEN_REPEAT_EN
    assign launch_req = bus.start;
`else
    // armed_q blocks a start that was already high when reset released.
    logic start_prev_q, start_prev_d;
    logic armed_q, armed_d;

    assign launch_req = bus.start & ~start_prev_q & armed_q;

    always_comb begin
        start_prev_d = bus.start;
        armed_d      = armed_q | ~bus.start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            armed_q      <= armed_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        dout_d      = 1'b0;
        dout_vld_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (launch_req) load = 1'b1;
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d     = S_GAP;
                    gap_cnt_d   = 4'd1;
                    busy_d      = 1'b1;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 3'd1;
                end else begin
                    dout_d     = shift_q[DATA_W-1];
                    dout_vld_d = 1'b1;
                    busy_d     = 1'b1;
                    shift_d    = shift_q << 1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
`ifdef SEQ_GEN_REPEAT_EN
                    if (launch_req) load = 1'b1;
                    else            state_d = S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                    busy_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The first bit leaves straight from the pattern so it appears one cycle after launch.
        if (load) begin
            state_d    = S_SHIFT;
            dout_d     = bus.pattern[DATA_W-1];
            dout_vld_d = 1'b1;
            busy_d     = 1'b1;
            shift_d    = bus.pattern << 1;
            bit_cnt_d  = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            dout_q      <= 1'b0;
            dout_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        case (frame_cnt_q)
            3'd0:    bus.seg = 8'h3F;
            3'd1:    bus.seg = 8'h06;
            3'd2:    bus.seg = 8'h5B;
            3'd3:    bus.seg = 8'h4F;
            3'd4:    bus.seg = 8'h66;
            3'd5:    bus.seg = 8'h6D;
            3'd6:    bus.seg = 8'h7D;
            default: bus.seg = 8'h07;
        endcase
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_seq_generator.sv
// Self-checking bench for seq_generator: frame-timing model compared every cycle plus directed literal checks.
// Build with SEQ_GEN_REPEAT_EN defined to exercise the repeat-launch expectations.
module tb_seq_generator;
    localparam int DATA_W    = 8;
    localparam int GAP       = 2;
    localparam int FRAME_LEN = DATA_W + GAP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    seq_generator_if #(.DATA_W(DATA_W)) bus ();

    seq_generator #(.DATA_W(DATA_W), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] segOf(input int n);
        case (n % 8)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            default: return 8'h07;
        endcase
    endfunction

    // Model: a frame is described only by the cycle it launched; outputs follow from the offset k.
    int                cyc         = 0;
    int                launch_at   = 0;
    bit                have_launch = 1'b0;
    int                frames_done = 0;
    bit                m_prev      = 1'b0;
    bit                m_armed     = 1'b0;
    logic [DATA_W-1:0] m_pat       = '0;
    int                k_old;
    bit                m_launch;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_launch = 1'b0;
            frames_done = 0;
            m_prev      = 1'b0;
            m_armed     = 1'b0;
        end else begin
            k_old = cyc - launch_at;
`ifdef SEQ_GEN_REPEAT_EN
            m_launch = bus.start && (!have_launch || k_old >= FRAME_LEN);
`else
            m_launch = bus.start && !m_prev && m_armed && (!have_launch || k_old > FRAME_LEN);
`endif
            m_prev = bus.start;
            if (!bus.start) m_armed = 1'b1;
            if (m_launch) begin
                launch_at   = cyc;
                have_launch = 1'b1;
                m_pat       = bus.pattern;
            end
            cyc++;
            if (have_launch && (cyc - launch_at) == DATA_W + 1) frames_done++;
        end
    end

    int   k;
    logic e_vld, e_dout, e_busy, e_done;

    always @(negedge clk) begin
        if (rst_n && checking) begin
            k      = cyc - launch_at;
            e_vld  = have_launch && k >= 1 && k <= DATA_W;
            e_dout = e_vld ? m_pat[DATA_W-k] : 1'b0;
            e_busy = have_launch && k >= 1 && k <= FRAME_LEN;
            e_done = have_launch && k == DATA_W + 1;
            checkOutput("model_dout",     32'(bus.dout),     32'(e_dout));
            checkOutput("model_dout_vld", 32'(bus.dout_vld), 32'(e_vld));
            checkOutput("model_busy",     32'(bus.busy),     32'(e_busy));
            checkOutput("model_done",     32'(bus.done),     32'(e_done));
            checkOutput("model_seg",      32'(bus.seg),      32'(segOf(frames_done)));
        end
    end

    // Downstream non-overlapping "11" detector fed by the serial stream.
    int det_count = 0;
    bit det_one   = 1'b0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            det_one = 1'b0;
        end else begin
            if (bus.done) done_seen++;
            if (bus.dout_vld) begin
                if (bus.dout && det_one) begin
                    det_count++;
                    det_one = 1'b0;
                end else begin
                    det_one = bus.dout;
                end
            end else begin
                det_one = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic [DATA_W-1:0] p);
        @(negedge clk);
        bus.start   = s;
        bus.pattern = p;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic runFrame(input logic [DATA_W-1:0] p);
        applyStimulus(1'b1, p);
        applyStimulus(1'b0, p);
        waitCycles(FRAME_LEN);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);
    endtask

    logic [7:0] exp_bits;
    logic [7:0] seg_lit [8];
    int         snap;

    initial begin
        bus.start   = 1'b0;
        bus.pattern = '0;
        seg_lit     = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h3F};

        #12;
        checkOutput("reset_dout",     32'(bus.dout),     32'd0);
        checkOutput("reset_dout_vld", 32'(bus.dout_vld), 32'd0);
        checkOutput("reset_busy",     32'(bus.busy),     32'd0);
        checkOutput("reset_done",     32'(bus.done),     32'd0);
        checkOutput("reset_seg",      32'(bus.seg),      32'h3F);
        @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;
        waitCycles(2);

        $display("[TB] single frame 8'hD6");
        exp_bits = 8'hD6;
        applyStimulus(1'b1, 8'hD6);
        applyStimulus(1'b0, 8'hD6);
        for (int i = 1; i <= DATA_W; i++) begin
            if (i > 1) @(negedge clk);
            checkOutput($sformatf("d6_bit%0d", i), 32'(bus.dout), 32'(exp_bits[DATA_W-i]));
            checkOutput($sformatf("d6_vld%0d", i), 32'(bus.dout_vld), 32'd1);
        end
        @(negedge clk);
        checkOutput("d6_done_cycle9", 32'(bus.done), 32'd1);
        checkOutput("d6_seg_after",   32'(bus.seg),  32'h06);
        waitCycles(2);

        $display("[TB] counter wrap over eight frames");
        for (int f = 1; f < 8; f++) begin
            runFrame(8'h11 * f[7:0] ^ 8'hA3);
            checkOutput($sformatf("wrap_seg%0d", f), 32'(bus.seg), 32'(seg_lit[f]));
        end

        $display("[TB] start and pattern change mid-frame");
        snap = done_seen;
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b0, 8'hA5);
        waitCycles(2);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b0, 8'h00);
        waitCycles(FRAME_LEN + 3);
        checkOutput("midframe_done_count", 32'(done_seen - snap), 32'd1);
        checkOutput("midframe_seg",        32'(bus.seg),          32'h06);
        checkOutput("midframe_idle",       32'(bus.busy),         32'd0);

        $display("[TB] reset mid-frame with start held");
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b0, 8'hC3);
        waitCycles(4);
        #1;
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.pattern = 8'h00;
        #1;
        checkOutput("abort_dout",     32'(bus.dout),     32'd0);
        checkOutput("abort_dout_vld", 32'(bus.dout_vld), 32'd0);
        checkOutput("abort_busy",     32'(bus.busy),     32'd0);
        checkOutput("abort_done",     32'(bus.done),     32'd0);
        checkOutput("abort_seg",      32'(bus.seg),      32'h3F);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(4);
`ifndef SEQ_GEN_REPEAT_EN
        checkOutput("held_start_no_launch", 32'(bus.busy), 32'd0);
`endif
        applyStimulus(1'b0, 8'h96);
        waitCycles(FRAME_LEN + 2);
        runFrame(8'h96);
`ifdef SEQ_GEN_REPEAT_EN
        checkOutput("post_reset_seg", 32'(bus.seg), 32'h5B);
`else
        checkOutput("post_reset_seg", 32'(bus.seg), 32'h06);
`endif

        $display("[TB] start held for 40 cycles");
        doReset();
        snap = done_seen;
        applyStimulus(1'b1, 8'hD6);
        waitCycles(39);
        applyStimulus(1'b0, 8'hD6);
        waitCycles(15);
`ifdef SEQ_GEN_REPEAT_EN
        checkOutput("held_done_count", 32'(done_seen - snap), 32'd4);
        checkOutput("held_seg",        32'(bus.seg),          32'h66);
`else
        checkOutput("held_done_count", 32'(done_seen - snap), 32'd1);
        checkOutput("held_seg",        32'(bus.seg),          32'h06);
`endif

        $display("[TB] loopback into 11 detector");
        snap = det_count;
        for (int f = 0; f < 3; f++) runFrame(8'hD6);
        checkOutput("detector_count", 32'(det_count - snap), 32'd6);

        waitCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
